// File: rtl/uart_i2c_cmd_decoder_if.sv
// Command-decoder bus: UART byte stream in, I2C command handshake and error pulses out.
interface uart_i2c_cmd_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [7:0]  cmd_mode;
  logic [7:0]  cmd_address;
  logic [15:0] cmd_wdata;
  logic        busy;
  logic        err_mode;
  logic        err_timeout;
  logic        err_overrun;

  modport master (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_valid, cmd_mode, cmd_address, cmd_wdata, busy,
    output err_mode, err_timeout, err_overrun
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_valid, cmd_mode, cmd_address, cmd_wdata, busy,
    input  err_mode, err_timeout, err_overrun
  );
endinterface

// File: rtl/uart_i2c_cmd_decoder.sv
// Assembles mode/address/data UART frames into I2C commands; cmd_valid rises 1 cycle after last byte.
// Holds command until cmd_ready; rx cannot stall, so bytes arriving while stalled are dropped and flagged.
module uart_i2c_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input logic                  clk,
  input logic                  reset,
  uart_i2c_cmd_decoder_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_HI, GET_LO, ISSUE} state_t;

  state_t        state, state_n;
  logic [7:0]    mode_q, mode_n;
  logic [7:0]    addr_q, addr_n;
  logic [15:0]   wdata_q, wdata_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          em_q, em_n, et_q, et_n, eo_q, eo_n;
  logic          take_mode;
  logic          mode_legal;

  assign mode_legal = (bus.rx_data == 8'h01) || (bus.rx_data == 8'h02) ||
                      (bus.rx_data == 8'h04) || (bus.rx_data == 8'h08);

  // A byte arriving on the handshake cycle starts the next frame instead of overrunning.
  assign take_mode = bus.rx_valid && ((state == IDLE) || (state == ISSUE && bus.cmd_ready));

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    cnt_n   = cnt_q;
    em_n    = 1'b0;
    et_n    = 1'b0;
    eo_n    = 1'b0;

    case (state)
      IDLE: cnt_n = '0;
      GET_ADDR, GET_HI, GET_LO: begin
        if (bus.rx_valid) begin
          cnt_n = '0;
          if (state == GET_ADDR) begin
            addr_n = bus.rx_data;
            if (mode_q[0] || mode_q[1]) state_n = ISSUE;
            else if (mode_q[2])         state_n = GET_LO;
            else                        state_n = GET_HI;
          end else if (state == GET_HI) begin
            wdata_n[15:8] = bus.rx_data;
            state_n       = GET_LO;
          end else begin
            wdata_n[7:0] = bus.rx_data;
            if (mode_q[2]) wdata_n[15:8] = 8'h00;
            state_n = ISSUE;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          et_n    = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      ISSUE: begin
        cnt_n = '0;
        if (bus.cmd_ready)     state_n = IDLE;
        else if (bus.rx_valid) eo_n    = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (take_mode) begin
      if (mode_legal) begin
        mode_n  = bus.rx_data;
        wdata_n = 16'h0000;
        state_n = GET_ADDR;
      end else begin
        em_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      em_q    <= 1'b0;
      et_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      cnt_q   <= cnt_n;
      em_q    <= em_n;
      et_q    <= et_n;
      eo_q    <= eo_n;
    end
  end

  assign bus.cmd_valid   = (state == ISSUE);
  assign bus.busy        = (state != IDLE);
  assign bus.cmd_mode    = mode_q;
  assign bus.cmd_address = addr_q;
  assign bus.cmd_wdata   = wdata_q;
  assign bus.err_mode    = em_q;
  assign bus.err_timeout = et_q;
  assign bus.err_overrun = eo_q;
endmodule

// File: tb/tb_uart_i2c_cmd_decoder.sv
// Directed bench for uart_i2c_cmd_decoder with a 16-cycle inter-byte timeout.
module tb_uart_i2c_cmd_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   n_xfer = 0;
  int   n_valid = 0;
  int   n_etimeout = 0;
  int   n_eoverrun = 0;

  always #5 clk = ~clk;

  uart_i2c_cmd_decoder_if bus ();

  uart_i2c_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.cmd_valid) n_valid++;
    if (bus.cmd_valid && bus.cmd_ready) n_xfer++;
    if (bus.err_timeout) n_etimeout++;
    if (bus.err_overrun) n_eoverrun++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.cmd_ready = 1'b0;
    reset = 1'b1;
    idle(3);
    total_cnt++;
    if ({bus.cmd_valid, bus.busy, bus.err_mode, bus.err_timeout, bus.err_overrun} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {bus.cmd_valid, bus.busy, bus.err_mode, bus.err_timeout, bus.err_overrun});
    else pass_cnt++;
    total_cnt++;
    if ({bus.cmd_mode, bus.cmd_address, bus.cmd_wdata} !== 32'h0)
      $display("FAIL reset_data: got %h want 00000000", {bus.cmd_mode, bus.cmd_address, bus.cmd_wdata});
    else pass_cnt++;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_read2;
    int x0;
    bus.cmd_ready = 1'b1;
    x0 = n_xfer;
    send_byte(8'h02);
    idle(10);
    send_byte(8'h48);
    total_cnt++;
    if ({bus.cmd_valid, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata} !== {1'b1, 8'h02, 8'h48, 16'h0000})
      $display("FAIL rd2_cmd: got v=%b m=%h a=%h d=%h want v=1 m=02 a=48 d=0000",
               bus.cmd_valid, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata);
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if ({bus.cmd_valid, bus.busy, bus.cmd_mode} !== {1'b0, 1'b0, 8'h02})
      $display("FAIL rd2_drop: got v=%b busy=%b m=%h want v=0 busy=0 m=02",
               bus.cmd_valid, bus.busy, bus.cmd_mode);
    else pass_cnt++;
    total_cnt++;
    if (n_xfer - x0 !== 1) $display("FAIL rd2_xfers: got %0d want 1", n_xfer - x0);
    else pass_cnt++;
  endtask

  task automatic test_write2_stall;
    int bad;
    int x0;
    bad = 0;
    bus.cmd_ready = 1'b0;
    x0 = n_xfer;
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    for (int i = 0; i < 20; i++) begin
      if ({bus.cmd_valid, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata} !== {1'b1, 8'h08, 8'h01, 16'h1234})
        bad++;
      if (i < 19) @(negedge clk);
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL wr2_stable: got %0d bad cycles want 0", bad);
    else pass_cnt++;
    bus.cmd_ready = 1'b1;
    idle(1);
    total_cnt++;
    if (bus.cmd_valid !== 1'b0) $display("FAIL wr2_drop: got v=%b want 0", bus.cmd_valid);
    else pass_cnt++;
    idle(3);
    total_cnt++;
    if (n_xfer - x0 !== 1) $display("FAIL wr2_xfers: got %0d want 1", n_xfer - x0);
    else pass_cnt++;
  endtask

  task automatic test_write1_badmode;
    int v0;
    bus.cmd_ready = 1'b1;
    send_byte(8'h04); send_byte(8'h05); send_byte(8'hAB);
    total_cnt++;
    if ({bus.cmd_valid, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata} !== {1'b1, 8'h04, 8'h05, 16'h00AB})
      $display("FAIL wr1_cmd: got v=%b m=%h a=%h d=%h want v=1 m=04 a=05 d=00AB",
               bus.cmd_valid, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata);
    else pass_cnt++;
    idle(2);
    v0 = n_valid;
    send_byte(8'h03);
    total_cnt++;
    if ({bus.err_mode, bus.busy, bus.cmd_valid} !== 3'b100)
      $display("FAIL badmode_pulse: got em/busy/v=%b want 100", {bus.err_mode, bus.busy, bus.cmd_valid});
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if ({bus.err_mode, bus.busy} !== 2'b00)
      $display("FAIL badmode_end: got em/busy=%b want 00", {bus.err_mode, bus.busy});
    else pass_cnt++;
    idle(3);
    total_cnt++;
    if (n_valid !== v0) $display("FAIL badmode_novalid: got %0d valid cycles want 0", n_valid - v0);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int k;
    int t0;
    k = 0;
    t0 = n_etimeout;
    send_byte(8'h08);
    send_byte(8'h01);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.err_timeout && k == 0) k = i;
    end
    total_cnt++;
    if (k < 16 || k > 17) $display("FAIL timeout_delay: got %0d cycles want 16..17", k);
    else pass_cnt++;
    total_cnt++;
    if ({bus.busy, n_etimeout - t0} !== {1'b0, 32'd1})
      $display("FAIL timeout_state: got busy=%b pulses=%0d want busy=0 pulses=1", bus.busy, n_etimeout - t0);
    else pass_cnt++;
    bus.cmd_ready = 1'b1;
    send_byte(8'h01);
    send_byte(8'h22);
    total_cnt++;
    if ({bus.cmd_valid, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata} !== {1'b1, 8'h01, 8'h22, 16'h0000})
      $display("FAIL after_timeout_cmd: got v=%b m=%h a=%h d=%h want v=1 m=01 a=22 d=0000",
               bus.cmd_valid, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata);
    else pass_cnt++;
    idle(2);
  endtask

  task automatic test_slow_frame;
    int t0;
    t0 = n_etimeout;
    bus.cmd_ready = 1'b0;
    send_byte(8'h08); idle(14);
    send_byte(8'hC3); idle(14);
    send_byte(8'h9A); idle(14);
    send_byte(8'h5E);
    total_cnt++;
    if ({bus.cmd_valid, bus.cmd_address, bus.cmd_wdata, n_etimeout - t0} !== {1'b1, 8'hC3, 16'h9A5E, 32'd0})
      $display("FAIL slow_frame: got v=%b a=%h d=%h to=%0d want v=1 a=C3 d=9A5E to=0",
               bus.cmd_valid, bus.cmd_address, bus.cmd_wdata, n_etimeout - t0);
    else pass_cnt++;
    bus.cmd_ready = 1'b1;
    idle(2);
  endtask

  task automatic test_overrun;
    int o0;
    o0 = n_eoverrun;
    bus.cmd_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h33);
    send_byte(8'hAA);
    total_cnt++;
    if ({bus.err_overrun, bus.cmd_valid, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata} !==
        {1'b1, 1'b1, 8'h01, 8'h33, 16'h0000})
      $display("FAIL overrun: got eo=%b v=%b m=%h a=%h d=%h want eo=1 v=1 m=01 a=33 d=0000",
               bus.err_overrun, bus.cmd_valid, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata);
    else pass_cnt++;
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    bus.rx_data   = 8'h02;
    bus.rx_valid  = 1'b1;
    @(negedge clk);
    bus.rx_valid  = 1'b0;
    total_cnt++;
    if ({bus.cmd_valid, bus.busy, bus.err_overrun, bus.cmd_mode, n_eoverrun - o0} !==
        {1'b0, 1'b1, 1'b0, 8'h02, 32'd1})
      $display("FAIL hs_byte: got v=%b busy=%b eo=%b m=%h ovr=%0d want v=0 busy=1 eo=0 m=02 ovr=1",
               bus.cmd_valid, bus.busy, bus.err_overrun, bus.cmd_mode, n_eoverrun - o0);
    else pass_cnt++;
    send_byte(8'h44);
    total_cnt++;
    if ({bus.cmd_valid, bus.cmd_mode, bus.cmd_address} !== {1'b1, 8'h02, 8'h44})
      $display("FAIL hs_next_cmd: got v=%b m=%h a=%h want v=1 m=02 a=44",
               bus.cmd_valid, bus.cmd_mode, bus.cmd_address);
    else pass_cnt++;
    idle(2);
  endtask

  task automatic test_reset_mid;
    int v0;
    bus.cmd_ready = 1'b0;
    send_byte(8'h08); send_byte(8'h01);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    total_cnt++;
    if ({bus.cmd_valid, bus.busy, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata} !== 34'h0)
      $display("FAIL reset_gethi: got v=%b busy=%b m=%h a=%h d=%h want all 0",
               bus.cmd_valid, bus.busy, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata);
    else pass_cnt++;
    send_byte(8'h01); send_byte(8'h55);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    total_cnt++;
    if ({bus.cmd_valid, bus.busy, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata} !== 34'h0)
      $display("FAIL reset_issue: got v=%b busy=%b m=%h a=%h d=%h want all 0",
               bus.cmd_valid, bus.busy, bus.cmd_mode, bus.cmd_address, bus.cmd_wdata);
    else pass_cnt++;
    v0 = n_valid;
    bus.cmd_ready = 1'b1;
    idle(25);
    total_cnt++;
    if (n_valid !== v0) $display("FAIL reset_nocmd: got %0d valid cycles want 0", n_valid - v0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read2();
    test_write2_stall();
    test_write1_badmode();
    test_timeout();
    test_slow_frame();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
